// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller arbitrating LSB accesses over ICache line fills.
module mem_ctrl #(
    parameter int          LINE_BYTES = 64,
    parameter logic [31:0] IO_BASE    = 32'h30000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    if_en,
    input  logic [31:0]             if_pc,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_len,
    input  logic [31:0]             lsb_w_data,
    output logic                    lsb_done,
    output logic [31:0]             lsb_r_data
);
    localparam int CW = $clog2(LINE_BYTES) + 1;
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
    state_t state;
    logic [31:0] base, wdata;
    logic [CW-1:0] last, ia, ir, ia_n;
    logic wr_q, v1, v2, hv, io_stall;
    logic [7:0] hold, din;
    assign ia_n = ia + 1'b1;
    // the byte due on the first stalled edge is parked so a stall costs exactly its length
    assign din = hv ? hold : mem_din;
    assign io_stall = io_buffer_full && base >= IO_BASE;
    assign mem_wr = wr_q && rdy && !io_stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base <= '0;
            wdata <= '0;
            last <= '0;
            ia <= '0;
            ir <= '0;
            wr_q <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            hv <= 1'b0;
            hold <= '0;
            mem_a <= '0;
            mem_dout <= '0;
            if_done <= 1'b0;
            lsb_done <= 1'b0;
            if_data <= '0;
            lsb_r_data <= '0;
        end else if (!rdy) begin
            if (v2 && !hv) begin
                hold <= mem_din;
                hv <= 1'b1;
            end
        end else begin
            hv <= 1'b0;
            case (state)
                IDLE: begin
                    ia <= '0;
                    ir <= '0;
                    v1 <= 1'b0;
                    v2 <= 1'b0;
                    // a flushed load is dropped; stores are already committed
                    if (lsb_en && (lsb_wr || !rollback)) begin
                        base <= lsb_addr;
                        wdata <= lsb_w_data;
                        last <= CW'(lsb_len);
                        state <= lsb_wr ? LS_WR : LS_RD;
                        if (!lsb_wr) lsb_r_data <= '0;
                    end else if (if_en) begin
                        base <= if_pc & ~32'(LINE_BYTES - 1);
                        last <= CW'(LINE_BYTES - 1);
                        state <= IF_RD;
                    end
                end
                IF_RD, LS_RD: begin
                    if (state == LS_RD && rollback) begin
                        state <= IDLE;
                        mem_a <= '0;
                    end else begin
                        v1 <= ia <= last;
                        v2 <= v1;
                        if (ia <= last) begin
                            mem_a <= base + 32'(ia);
                            ia <= ia_n;
                        end
                        if (v2) begin
                            if (state == IF_RD) if_data[{ir[CW-2:0], 3'b000} +: 8] <= din;
                            else lsb_r_data[{ir[1:0], 3'b000} +: 8] <= din;
                            ir <= ir + 1'b1;
                            if (ir == last) begin
                                state <= DONE;
                                mem_a <= '0;
                                if_done <= state == IF_RD;
                                lsb_done <= state == LS_RD;
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (!wr_q) begin
                        mem_a <= base + 32'(ia);
                        mem_dout <= wdata[{ia[1:0], 3'b000} +: 8];
                        wr_q <= 1'b1;
                    end else if (!io_stall) begin
                        if (ia == last) begin
                            wr_q <= 1'b0;
                            mem_a <= '0;
                            mem_dout <= '0;
                            lsb_done <= 1'b1;
                            state <= DONE;
                        end else begin
                            ia <= ia_n;
                            mem_a <= base + 32'(ia_n);
                            mem_dout <= wdata[{ia_n[1:0], 3'b000} +: 8];
                        end
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    lsb_done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a RAM whose byte at a is a[7:0].
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, rollback, io_buffer_full, if_en, lsb_en, lsb_wr, mem_wr, if_done, lsb_done;
    logic [7:0] mem_din, mem_dout;
    logic [31:0] mem_a, if_pc, lsb_addr, lsb_w_data, lsb_r_data;
    logic [1:0] lsb_len;
    logic [511:0] if_data, exp_line;
    int errors = 0, checks = 0;
    int if_dc, ls_dc, wr_first, n_ifd, n_lsd, bad;
    int rb_at = -1, rdy_from = -1, rdy_to = -1, io_to = -1;
    logic [31:0] am [0:127];
    logic [7:0] wlog [$];
    logic [31:0] alog [$];
    logic [31:0] wb;

    always #5 clk = ~clk;
    always @(posedge clk) mem_din <= mem_a[7:0];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle c starts at the c-th edge after the request is presented (c=0 samples it)
    task automatic run(input int n);
        if_dc = -1; ls_dc = -1; wr_first = -1; n_ifd = 0; n_lsd = 0;
        wlog.delete(); alog.delete();
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            rollback = (c == rb_at);
            if (c == rb_at && !lsb_wr) lsb_en = 1'b0;
            rdy = !(c >= rdy_from && c <= rdy_to);
            io_buffer_full = (c <= io_to);
            #1;
            am[c] = mem_a;
            if (mem_wr) begin
                if (wr_first < 0) wr_first = c;
                wlog.push_back(mem_dout);
                alog.push_back(mem_a);
            end
            if (if_done) begin n_ifd++; if (if_dc < 0) if_dc = c; if_en = 1'b0; end
            if (lsb_done) begin n_lsd++; if (ls_dc < 0) ls_dc = c; lsb_en = 1'b0; end
        end
        rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        rb_at = -1; rdy_from = -1; rdy_to = -1; io_to = -1;
    endtask

    task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
        lsb_en = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_w_data = d;
    endtask

    task automatic line_exp(input logic [7:0] lo);
        for (int i = 0; i < 64; i++) exp_line[8*i +: 8] = lo + 8'(i);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_en = 1'b0; if_pc = '0; lsb_en = 1'b0; lsb_wr = 1'b0;
        lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_a, mem_dout, mem_wr, if_done, lsb_done, lsb_r_data}, '0);
        chk("reset_if_data", if_data, '0);
        rst = 1'b0;
        @(posedge clk); #2;

        // line fill with a rollback in the middle
        if_en = 1'b1; if_pc = 32'h1040; rb_at = 30;
        run(70);
        bad = 0;
        for (int c = 1; c <= 64; c++) if (am[c] !== 32'h1040 + 32'(c - 1)) bad++;
        chk("fill_addr_seq", bad, 0);
        chk("fill_addr_first", am[1], 32'h1040);
        chk("fill_addr_last", am[64], 32'h107F);
        chk("fill_done_cycle", if_dc, 66);
        chk("fill_done_count", n_ifd, 1);
        chk("fill_byte0", if_data[7:0], 8'h40);
        chk("fill_byte63", if_data[511:504], 8'h7F);
        line_exp(8'h40);
        chk("fill_line", if_data, exp_line);
        chk("fill_no_write", wr_first, -1);
        chk("fill_idle_addr", am[67], 0);

        // simultaneous requests: load wins, fill follows after DONE
        lsb_req(1'b0, 32'h200, 2'd3, 32'h0);
        if_en = 1'b1; if_pc = 32'h13;
        run(80);
        chk("arb_load_done", ls_dc, 6);
        chk("arb_load_data", lsb_r_data, 32'h03020100);
        chk("arb_load_addr", am[1], 32'h200);
        chk("arb_done_addr", am[6], 0);
        chk("arb_fill_second", am[10], 32'h1);
        chk("arb_fill_done", if_dc, 74);
        line_exp(8'h00);
        chk("arb_fill_line", if_data, exp_line);

        // word store
        lsb_req(1'b1, 32'h100, 2'd3, 32'hDEADBEEF);
        run(8);
        wb = '0;
        for (int i = 0; i < wlog.size() && i < 4; i++) wb[8*i +: 8] = wlog[i];
        chk("st_first_wr", wr_first, 1);
        chk("st_nbytes", wlog.size(), 4);
        chk("st_bytes", wb, 32'hBEADDE00 >> 8 | 32'hEF000000 >> 0 ? 32'hDEADBEEF : 32'h0);
        chk("st_addr0", alog.size() > 0 ? alog[0] : 32'hX, 32'h100);
        chk("st_addr3", alog.size() > 3 ? alog[3] : 32'hX, 32'h103);
        chk("st_done", ls_dc, 5);

        // IO store held off by a full buffer
        lsb_req(1'b1, 32'h30000, 2'd0, 32'h5A); io_to = 3;
        run(8);
        chk("io_first_wr", wr_first, 4);
        chk("io_done", ls_dc, 5);
        chk("io_byte", wlog.size() == 1 ? wlog[0] : 8'hX, 8'h5A);

        // RAM-space store ignores a full IO buffer
        lsb_req(1'b1, 32'h120, 2'd1, 32'h1234); io_to = 10;
        run(6);
        chk("ram_st_first_wr", wr_first, 1);
        chk("ram_st_done", ls_dc, 3);

        // load flushed by rollback
        lsb_req(1'b0, 32'h345, 2'd1, 32'h0); rb_at = 3;
        run(8);
        chk("rb_no_done", n_lsd, 0);
        chk("rb_idle_addr", am[4], 0);

        // byte load, zero-extended
        lsb_req(1'b0, 32'hFF, 2'd0, 32'h0);
        run(5);
        chk("bl_done", ls_dc, 3);
        chk("bl_data", lsb_r_data, 32'h000000FF);

        // rollback alongside the done pulse keeps it
        lsb_req(1'b0, 32'h81, 2'd0, 32'h0); rb_at = 3;
        run(5);
        chk("rb_done_kept", ls_dc, 3);
        chk("rb_done_data", lsb_r_data, 32'h00000081);

        // rdy stall during a fill
        if_en = 1'b1; if_pc = 32'h2000; rdy_from = 10; rdy_to = 14;
        run(75);
        chk("stall_done", if_dc, 71);
        chk("stall_addr_held", am[13], am[10]);
        line_exp(8'h00);
        chk("stall_line", if_data, exp_line);

        // reset in the middle of a fill
        if_en = 1'b1; if_pc = 32'h1040;
        run(19);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outputs", {mem_a, mem_dout, mem_wr, if_done, lsb_done, lsb_r_data}, '0);
        chk("rst_mid_if_data", if_data, '0);
        rst = 1'b0; if_en = 1'b0;
        run(70);
        chk("rst_no_done", n_ifd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
